interpolation_ram_arbiter: RTL and testbench
============================================

Name: interpolation_ram_arbiter

Overview:
- Shares the single-write/dual-read interpolation RAM between two requesters: A = Interpolation unit, B = solver core / coefficient loader.
- Grants exclusive ownership of all RAM address/write ports to one requester at a time.
- Uses round-robin fairness on contention and inserts one idle turnaround cycle on every ownership change.
- Sits between both requesters and the RAM. RAM read data is wired directly to both requesters, not through this block.

Parameters:
- RAM_ADDRESS_WIDTH, 13, address width of every address port.
- DATA_WIDTH, 64, width of write data.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- A_Req  input  1  requester A wants ownership; held high for the whole transaction.
- A_Grant  output  1  A owns the RAM ports.
- A_WR_Enable  input  1  A write strobe.
- A_WR_Address  input  RAM_ADDRESS_WIDTH  A write address.
- A_WR_Data  input  DATA_WIDTH  A write data.
- A_RD1_Address, A_RD2_Address  input  RAM_ADDRESS_WIDTH each  A read addresses.
- B_Req, B_Grant, B_WR_Enable, B_WR_Address, B_WR_Data, B_RD1_Address, B_RD2_Address  mirror of A_* for requester B.
- RAM_WR_Enable  output  1  to RAM write enable.
- RAM_WR_Address  output  RAM_ADDRESS_WIDTH  to RAM.
- RAM_WR_Data  output  DATA_WIDTH  to RAM.
- RAM_RD1_Address, RAM_RD2_Address  output  RAM_ADDRESS_WIDTH each  to RAM.
- Owner  output  2  00 none, 01 A, 10 B (11 never driven).
- Access_Error  output  1  sticky: a requester strobed WR_Enable without holding grant.

Behaviour:
- FSM states: IDLE, OWN_A, OWN_B, TURN (turnaround). Registered state; grants decode from state (Moore).
- Reset (asynchronous, immediate): state IDLE, Last_Served=B (so A wins first contention), A_Grant=0, B_Grant=0, Owner=00, Access_Error=0, RAM_WR_Enable=0, all RAM address/data outputs 0.
- IDLE:
  - Only A_Req -> OWN_A next edge.
  - Only B_Req -> OWN_B next edge.
  - Both -> the requester not equal to Last_Served.
  - Neither -> stay in IDLE.
  - Grant latency from Req rising in IDLE = 1 cycle.
- OWN_A: stay while A_Req=1. On A_Req=0 -> TURN, Last_Served=A. OWN_B is symmetric.
- TURN: exactly one cycle with no grant and no RAM write, then the same decision as IDLE.
  - Consequence: hand-over latency from owner's Req falling to the other's Grant = 2 cycles.
- Ownership is non-preemptive. The other requester's Req is ignored until the owner releases.
- Port muxing (combinational from registered state):
  - OWN_A: RAM_* = A_* and RAM_WR_Enable = A_WR_Enable.
  - OWN_B: same with B_*.
  - IDLE/TURN: RAM_WR_Enable=0, addresses/data=0.
- Write gating: a requester's WR_Enable while not granted is never forwarded. It sets Access_Error on the next edge; only RST clears it.
- Req dropped and re-raised by the owner in consecutive cycles: TURN is still inserted, then fresh arbitration. The other requester wins if it is waiting.
- Simultaneous owner release and other request: handled by TURN, no special case.
- RST mid-transaction: grant drops immediately (async), the in-flight write is not issued, arbitration restarts from IDLE with A priority.
- Read data timing is the RAM's own. The requester must keep addresses stable while granted and samples RAM RD data directly.
- Target size: ~150–250 lines RTL.

Test Plan:
- Reset then A_Req=1 alone -> A_Grant=1, Owner=01 after 1 edge. A_WR_Enable=1, A_WR_Address=5, A_WR_Data=64'hDEAD -> RAM_WR_Enable=1, RAM_WR_Address=5, RAM_WR_Data=64'hDEAD same cycle.
- A_Req and B_Req rise the same cycle from reset -> A granted first. A drops Req -> 1 cycle with Owner=00, then B_Grant=1. Repeat contention -> A again, alternating thereafter.
- B owns; A_Req=1 for 20 cycles -> A_Grant stays 0, B_Grant stays 1 until B_Req=0. A_Grant asserts 2 cycles after B_Req falls.
- While B owns, A_WR_Enable=1 at address 7 -> RAM_WR_Enable reflects only B's strobe, address 7 never written, Access_Error=1 and stays 1 until RST.
- RST asserted mid-write in OWN_A -> A_Grant, RAM_WR_Enable, Owner fall without waiting for a clock edge. After release with B_Req=1 only -> B granted 1 cycle later.
- Owner A toggles A_Req 1→0→1 on consecutive cycles with B idle -> sequence OWN_A, TURN, OWN_A (A_Grant low exactly one cycle).

Source files
------------

// File: rtl/interpolation_ram_arbiter.sv
// interpolation_ram_arbiter: round-robin owner of the interpolation RAM ports shared by the interpolation unit (A) and the solver/loader (B)
module interpolation_ram_arbiter #(
  parameter int RAM_ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH        = 64
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         A_Req,
  output logic                         A_Grant,
  input  logic                         A_WR_Enable,
  input  logic [RAM_ADDRESS_WIDTH-1:0] A_WR_Address,
  input  logic [DATA_WIDTH-1:0]        A_WR_Data,
  input  logic [RAM_ADDRESS_WIDTH-1:0] A_RD1_Address,
  input  logic [RAM_ADDRESS_WIDTH-1:0] A_RD2_Address,
  input  logic                         B_Req,
  output logic                         B_Grant,
  input  logic                         B_WR_Enable,
  input  logic [RAM_ADDRESS_WIDTH-1:0] B_WR_Address,
  input  logic [DATA_WIDTH-1:0]        B_WR_Data,
  input  logic [RAM_ADDRESS_WIDTH-1:0] B_RD1_Address,
  input  logic [RAM_ADDRESS_WIDTH-1:0] B_RD2_Address,
  output logic                         RAM_WR_Enable,
  output logic [RAM_ADDRESS_WIDTH-1:0] RAM_WR_Address,
  output logic [DATA_WIDTH-1:0]        RAM_WR_Data,
  output logic [RAM_ADDRESS_WIDTH-1:0] RAM_RD1_Address,
  output logic [RAM_ADDRESS_WIDTH-1:0] RAM_RD2_Address,
  output logic [1:0]                   Owner,
  output logic                         Access_Error
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, TURN} state_t;
  state_t state, state_nx;
  logic last_b, last_b_nx;
  always_comb begin
    state_nx  = state;
    last_b_nx = last_b;
    case (state)
      OWN_A: if (!A_Req) begin
        state_nx  = TURN;
        last_b_nx = 1'b0;
      end
      OWN_B: if (!B_Req) begin
        state_nx  = TURN;
        last_b_nx = 1'b1;
      end
      default: state_nx = (A_Req && (!B_Req || last_b)) ? OWN_A : B_Req ? OWN_B : IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state        <= IDLE;
      last_b       <= 1'b1;
      Access_Error <= 1'b0;
    end else begin
      state  <= state_nx;
      last_b <= last_b_nx;
      if ((A_WR_Enable && !A_Grant) || (B_WR_Enable && !B_Grant)) Access_Error <= 1'b1;
    end
  assign A_Grant         = state == OWN_A;
  assign B_Grant         = state == OWN_B;
  assign Owner           = {B_Grant, A_Grant};
  assign RAM_WR_Enable   = A_Grant ? A_WR_Enable   : B_Grant ? B_WR_Enable   : 1'b0;
  assign RAM_WR_Address  = A_Grant ? A_WR_Address  : B_Grant ? B_WR_Address  : '0;
  assign RAM_WR_Data     = A_Grant ? A_WR_Data     : B_Grant ? B_WR_Data     : '0;
  assign RAM_RD1_Address = A_Grant ? A_RD1_Address : B_Grant ? B_RD1_Address : '0;
  assign RAM_RD2_Address = A_Grant ? A_RD2_Address : B_Grant ? B_RD2_Address : '0;
endmodule

// File: tb/tb_interpolation_ram_arbiter.sv
// tb_interpolation_ram_arbiter: directed and random traffic scored against an ownership-level reference model
module tb_interpolation_ram_arbiter;
  logic        CLK = 0, RST = 1;
  logic        A_Req = 0, A_WR_Enable = 0, B_Req = 0, B_WR_Enable = 0;
  logic [12:0] A_WR_Address = 0, A_RD1_Address = 0, A_RD2_Address = 0;
  logic [12:0] B_WR_Address = 0, B_RD1_Address = 0, B_RD2_Address = 0;
  logic [63:0] A_WR_Data = 0, B_WR_Data = 0;
  logic        A_Grant, B_Grant, RAM_WR_Enable, Access_Error;
  logic [12:0] RAM_WR_Address, RAM_RD1_Address, RAM_RD2_Address;
  logic [63:0] RAM_WR_Data;
  logic [1:0]  Owner;

  interpolation_ram_arbiter dut (
    .CLK(CLK), .RST(RST),
    .A_Req(A_Req), .A_Grant(A_Grant), .A_WR_Enable(A_WR_Enable), .A_WR_Address(A_WR_Address),
    .A_WR_Data(A_WR_Data), .A_RD1_Address(A_RD1_Address), .A_RD2_Address(A_RD2_Address),
    .B_Req(B_Req), .B_Grant(B_Grant), .B_WR_Enable(B_WR_Enable), .B_WR_Address(B_WR_Address),
    .B_WR_Data(B_WR_Data), .B_RD1_Address(B_RD1_Address), .B_RD2_Address(B_RD2_Address),
    .RAM_WR_Enable(RAM_WR_Enable), .RAM_WR_Address(RAM_WR_Address), .RAM_WR_Data(RAM_WR_Data),
    .RAM_RD1_Address(RAM_RD1_Address), .RAM_RD2_Address(RAM_RD2_Address),
    .Owner(Owner), .Access_Error(Access_Error)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ga, gb, we, err;
    logic [1:0]  own;
    logic [12:0] wa, r1, r2;
    logic [63:0] wd;
  } exp_t;
  exp_t q[$];

  int total = 0, bad = 0;
  int m_own = 0, m_last = 2;
  bit m_err = 0;

  function automatic void chk(string n, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, req, $time);
    end
  endfunction

  // Owner model: one holder at a time, a released owner leaves one empty cycle, ties go to whoever was not served last
  function automatic void model_step();
    m_err = m_err | (A_WR_Enable && m_own != 1) | (B_WR_Enable && m_own != 2);
    if (m_own == 1) begin
      if (!A_Req) begin m_own = 0; m_last = 1; end
    end else if (m_own == 2) begin
      if (!B_Req) begin m_own = 0; m_last = 2; end
    end else if (A_Req && B_Req) m_own = (m_last == 1) ? 2 : 1;
    else if (A_Req) m_own = 1;
    else if (B_Req) m_own = 2;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    e.ga  = m_own == 1;
    e.gb  = m_own == 2;
    e.own = m_own[1:0];
    e.err = m_err;
    e.we  = m_own == 1 ? A_WR_Enable : m_own == 2 ? B_WR_Enable : 1'b0;
    e.wa  = m_own == 1 ? A_WR_Address : m_own == 2 ? B_WR_Address : 13'd0;
    e.wd  = m_own == 1 ? A_WR_Data : m_own == 2 ? B_WR_Data : 64'd0;
    e.r1  = m_own == 1 ? A_RD1_Address : m_own == 2 ? B_RD1_Address : 13'd0;
    e.r2  = m_own == 1 ? A_RD2_Address : m_own == 2 ? B_RD2_Address : 13'd0;
    return e;
  endfunction

  task automatic cyc(input bit ar, input bit br, input bit aw, input bit bw, input bit fix = 0);
    @(posedge CLK);
    model_step();
    #1;
    A_Req = ar; B_Req = br; A_WR_Enable = aw; B_WR_Enable = bw;
    A_WR_Address = 13'($urandom); A_WR_Data = {$urandom, $urandom};
    A_RD1_Address = 13'($urandom); A_RD2_Address = 13'($urandom);
    B_WR_Address = 13'($urandom); B_WR_Data = {$urandom, $urandom};
    B_RD1_Address = 13'($urandom); B_RD2_Address = 13'($urandom);
    if (fix) begin A_WR_Address = 13'd5; A_WR_Data = 64'hDEAD; end
    q.push_back(expect_now());
  endtask

  task automatic do_reset(input bit ar, input bit br);
    @(negedge CLK);
    #1 RST = 1;
    #1;
    chk("rst_a_grant", A_Grant, 0);
    chk("rst_b_grant", B_Grant, 0);
    chk("rst_ram_we", RAM_WR_Enable, 0);
    chk("rst_owner", Owner, 0);
    chk("rst_err", Access_Error, 0);
    A_Req = ar; B_Req = br; A_WR_Enable = 0; B_WR_Enable = 0;
    @(posedge CLK);
    #1 RST = 0;
    m_own = 0; m_last = 2; m_err = 0;
  endtask

  always @(negedge CLK)
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("a_grant", A_Grant, e.ga);
      chk("b_grant", B_Grant, e.gb);
      chk("owner", Owner, e.own);
      chk("access_error", Access_Error, e.err);
      chk("ram_we", RAM_WR_Enable, e.we);
      chk("ram_wa", RAM_WR_Address, e.wa);
      chk("ram_wd", RAM_WR_Data, e.wd);
      chk("ram_rd1", RAM_RD1_Address, e.r1);
      chk("ram_rd2", RAM_RD2_Address, e.r2);
    end

  initial begin
    bit ar, br;
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0, 1);
    cyc(0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    do_reset(0, 0);
    repeat (3) cyc(1, 1, 0, 0);
    repeat (3) cyc(0, 1, 0, 1);
    repeat (20) cyc(1, 1, 1, 1);
    repeat (4) cyc(1, 0, 0, 0);
    repeat (2) cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (3) cyc(1, 1, 0, 0);
    do_reset(0, 0);
    repeat (2) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    do_reset(0, 1);
    repeat (3) cyc(0, 1, 0, 0);
    do_reset(0, 0);
    ar = 0; br = 0;
    repeat (500) begin
      if ($urandom_range(5) == 0) ar = ~ar;
      if ($urandom_range(5) == 0) br = ~br;
      cyc(ar, br, 1'($urandom_range(3) == 0), 1'($urandom_range(3) == 0));
    end
    @(negedge CLK);
    #1;
    chk("queue_drained", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
